seg7_count_sequencer: RTL and testbench
=======================================

Name: seg7_count_sequencer

Overview:
- Synchronous controller that sequences a 3-bit digit counter (values 0..7) and drives a 7-segment display. It replaces the free-running ripple-clocked counter with a single-clock design.
- Supports a run/pause state machine, a selectable-rate prescaler, single-step from a button, up/down direction, and parallel load.
- Sits between the tile's io_in pins (controls) and io_out pins (segments a..g plus dp).

Parameters:
- PRESCALE_W, 6, prescaler width; must be >= 4. Tick period is 2^(PRESCALE_W-3+rate_i) cycles.
- SYNC_STAGES, 2, flops in the step_i synchroniser; must be >= 2.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset. Assertion is asynchronous; release is synchronous to clk.
- run_i  input  1  level; 1 = auto-advance on prescaler tick.
- step_i  input  1  asynchronous button. Each synchronised rising edge advances the count once when not running.
- dir_i  input  1  0 = count up, 1 = count down.
- load_i  input  1  synchronous load strobe.
- load_val_i  input  3  value loaded when load_i = 1.
- rate_i  input  2  prescaler rate select.
- seg_o  output  7  segments; seg_o[0] = a .. seg_o[6] = g; active high.
- dp_o  output  1  wrap indicator.
- count_o  output  3  current count.

Behaviour:
- Reset: state = IDLE, count_o = 0, prescaler = 0, synchroniser = 0, dp_o = 0, seg_o = 7'h3F (digit 0).
- Reset assertion takes effect immediately, including mid-count.
- FSM states and transitions:
  - IDLE: go to RUN when run_i = 1.
  - RUN: go to PAUSED when run_i = 0.
  - PAUSED: go to RUN when run_i = 1.
  - IDLE is entered only from reset.
- Prescaler:
  - Increments every cycle in RUN; held at 0 in IDLE and PAUSED; cleared on load_i.
  - tick = 1 when low k bits are all ones, where k = PRESCALE_W-3+rate_i. Defaults give periods of 8/16/32/64 cycles.
  - A rate_i change mid-period applies immediately to the compare (no reset of the prescaler).
- step_i: passes through the SYNC_STAGES synchroniser, then rising-edge detect, giving a one-cycle step pulse.
- Advance event:
  - In RUN: tick.
  - In IDLE or PAUSED: step pulse.
  - A step pulse in RUN is ignored.
- Advance action:
  - Up: count = count+1 mod 8.
  - Down: count = count-1 mod 8.
  - dir_i is sampled in the advance cycle.
- Wrap: an up advance 7->0 or a down advance 0->7 sets dp_o. dp_o clears on the next non-wrapping advance or on load.
- Priority: load_i > advance.
  - On load: count = load_val_i, dp_o = 0, prescaler = 0.
  - A simultaneous tick or step is discarded.
  - The FSM still transitions per run_i in the same cycle.
- run_i dropping in the same cycle as a tick: the advance still happens, evaluated in the current state (RUN); the state becomes PAUSED.
- count_o updates one cycle after the event.
- seg_o is registered from the next-count value, so seg_o and count_o change in the same cycle.
- Segment map: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07.
- No combinational path from inputs to outputs.

Decomposition:
- Package seg7_seq_pkg:
  - state enum (IDLE, RUN, PAUSED)
  - SEG_LUT constant, 8 x 7-bit
  - function seg_encode(3-bit) -> 7-bit
- One sub-module: seg7_step_sync (SYNC_STAGES-flop synchroniser + rising-edge detector, async active-low reset).
- FSM, prescaler, counter and output registers stay in the top.

Test Plan:
- Reset: hold rst_n = 0 with all inputs toggling -> count_o = 0, seg_o = 3F, dp_o = 0. After release with run_i = 0 there are no changes for 200 cycles.
- Run up, rate_i = 0, dir_i = 0, run_i = 1 -> count_o increments every 8 cycles through 0..7,0. On the 7->0 advance dp_o = 1 and seg_o = 3F. dp_o clears at the 0->1 advance; seg_o for 3 = 4F.
- Run down, rate_i = 3, dir_i = 1 -> advances every 64 cycles: 0->7 sets dp_o, 7->6 clears it.
- Step: run_i = 0, apply three step_i pulses each 10 cycles wide -> count_o = 3 after the third, exactly one advance per pulse. A step pulse while run_i = 1 gives no extra advance.
- Load priority: with count_o = 5, assert load_i with load_val_i = 2 in the tick cycle -> count_o = 2, seg_o = 5B, dp_o = 0, next tick after 8 cycles.
- Async reset mid-run at count_o = 6 -> outputs return to reset values without waiting for a clk edge; state = IDLE even though run_i = 1 at assertion. On release with run_i = 1 the state moves to RUN on the first clock.

Source files
------------

// File: rtl/seg7_seq_pkg.sv
// Shared types and the 7-segment encoding for the digit sequencer.
package seg7_seq_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2
  } state_e;

  // Index 0 is the rightmost entry; segments are {g,f,e,d,c,b,a}, active high.
  localparam logic [7:0][6:0] SEG_LUT = {
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_encode(input logic [2:0] digit);
    return SEG_LUT[digit];
  endfunction

endpackage

// File: rtl/seg7_step_sync.sv
// Synchronises the asynchronous step button and emits a one-cycle pulse per rising edge.
module seg7_step_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_i,
  output logic step_pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], step_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign step_pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/seg7_count_sequencer.sv
// Run/pause/step sequencer for a 3-bit digit counter driving a registered 7-segment display.
module seg7_count_sequencer
  import seg7_seq_pkg::*;
#(
  parameter int unsigned PRESCALE_W  = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic       step_i,
  input  logic       dir_i,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  input  logic [1:0] rate_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic [2:0] count_o
);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] mask;
  logic [2:0]            count_q, count_d;
  logic                  dp_q, dp_d;
  logic [6:0]            seg_q;
  logic                  step_pulse;
  logic                  tick;
  logic                  advance;
  int unsigned           k;

  seg7_step_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_step_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .step_i       (step_i),
    .step_pulse_o (step_pulse)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (run_i)  state_d = StRun;
      StRun:    if (!run_i) state_d = StPaused;
      StPaused: if (run_i)  state_d = StRun;
      default:  state_d = StIdle;
    endcase
  end

  // Rate compare reads the live prescaler, so a rate change takes effect mid-period.
  always_comb begin
    k    = PRESCALE_W - 3 + int'(rate_i);
    mask = '0;
    for (int unsigned i = 0; i < PRESCALE_W; i++) begin
      mask[i] = (i < k);
    end
    tick    = (state_q == StRun) && ((presc_q & mask) == mask);
    advance = (state_q == StRun) ? tick : step_pulse;
  end

  always_comb begin
    presc_d = '0;
    count_d = count_q;
    dp_d    = dp_q;
    if ((state_q == StRun) && run_i && !load_i) begin
      presc_d = presc_q + PRESCALE_W'(1);
    end
    if (load_i) begin
      count_d = load_val_i;
      dp_d    = 1'b0;
    end else if (advance) begin
      if (dir_i) begin
        count_d = count_q - 3'd1;
        dp_d    = (count_q == 3'd0);
      end else begin
        count_d = count_q + 3'd1;
        dp_d    = (count_q == 3'd7);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      presc_q <= '0;
      count_q <= 3'd0;
      dp_q    <= 1'b0;
      seg_q   <= 7'h3F;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      dp_q    <= dp_d;
      seg_q   <= seg_encode(count_d);
    end
  end

  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_seg7_count_sequencer.sv
// Directed, table-driven bench for seg7_count_sequencer with hand-computed expectations.
module tb_seg7_count_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run_i = 1'b0;
  logic       step_i = 1'b0;
  logic       dir_i = 1'b0;
  logic       load_i = 1'b0;
  logic [2:0] load_val_i = 3'd0;
  logic [1:0] rate_i = 2'd0;
  logic [6:0] seg_o;
  logic       dp_o;
  logic [2:0] count_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] val;
    logic [2:0] exp_count;
    logic [6:0] exp_seg;
  } vec_t;

  vec_t vecs[8];

  seg7_count_sequencer #(
    .PRESCALE_W  (6),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_i      (run_i),
    .step_i     (step_i),
    .dir_i      (dir_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .rate_i     (rate_i),
    .seg_o      (seg_o),
    .dp_o       (dp_o),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_of(input logic [2:0] d);
    case (d)
      3'd0: return 7'h3F;
      3'd1: return 7'h06;
      3'd2: return 7'h5B;
      3'd3: return 7'h4F;
      3'd4: return 7'h66;
      3'd5: return 7'h6D;
      3'd6: return 7'h7D;
      default: return 7'h07;
    endcase
  endfunction

  task automatic expect_out(input string name, input logic [2:0] c, input logic dp);
    check({name, ".count"}, 32'(count_o), 32'(c));
    check({name, ".seg"}, 32'(seg_o), 32'(seg_of(c)));
    check({name, ".dp"}, 32'(dp_o), 32'(dp));
  endtask

  task automatic do_load(input logic [2:0] v);
    load_i = 1'b1;
    load_val_i = v;
    cyc(1);
    load_i = 1'b0;
  endtask

  initial begin
    int bad;
    vecs[0] = '{val: 3'd5, exp_count: 3'd5, exp_seg: 7'h6D};
    vecs[1] = '{val: 3'd2, exp_count: 3'd2, exp_seg: 7'h5B};
    vecs[2] = '{val: 3'd7, exp_count: 3'd7, exp_seg: 7'h07};
    vecs[3] = '{val: 3'd0, exp_count: 3'd0, exp_seg: 7'h3F};
    vecs[4] = '{val: 3'd3, exp_count: 3'd3, exp_seg: 7'h4F};
    vecs[5] = '{val: 3'd6, exp_count: 3'd6, exp_seg: 7'h7D};
    vecs[6] = '{val: 3'd1, exp_count: 3'd1, exp_seg: 7'h06};
    vecs[7] = '{val: 3'd4, exp_count: 3'd4, exp_seg: 7'h66};

    // Reset held with inputs toggling
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      run_i = $urandom_range(0, 1);
      step_i = $urandom_range(0, 1);
      dir_i = $urandom_range(0, 1);
      load_i = $urandom_range(0, 1);
      load_val_i = 3'($urandom_range(0, 7));
      rate_i = 2'($urandom_range(0, 3));
      cyc(1);
      if (count_o !== 3'd0 || seg_o !== 7'h3F || dp_o !== 1'b0) bad++;
    end
    check("reset_hold", 32'(bad), 32'd0);
    run_i = 0; step_i = 0; dir_i = 0; load_i = 0; load_val_i = 0; rate_i = 0;
    expect_out("reset", 3'd0, 1'b0);
    rst_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1);
      if (count_o !== 3'd0 || seg_o !== 7'h3F || dp_o !== 1'b0) bad++;
    end
    check("idle_no_change", 32'(bad), 32'd0);

    // Table: loads cover every digit of the segment map
    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].val);
      check($sformatf("load%0d.count", i), 32'(count_o), 32'(vecs[i].exp_count));
      check($sformatf("load%0d.seg", i), 32'(seg_o), 32'(vecs[i].exp_seg));
      check($sformatf("load%0d.dp", i), 32'(dp_o), 32'd0);
    end

    // Run up at rate 0: first advance 9 edges after run (IDLE->RUN takes one), then every 8
    do_load(3'd0);
    run_i = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      cyc(i == 1 ? 8 : 7);
      check($sformatf("up_hold%0d", i), 32'(count_o), 32'((i - 1) % 8));
      cyc(1);
      expect_out($sformatf("up%0d", i), 3'(i % 8), i == 8);
    end

    // Run down at rate 3 from 0
    run_i = 1'b0;
    cyc(1);
    do_load(3'd0);
    dir_i = 1'b1;
    rate_i = 2'd3;
    run_i = 1'b1;
    cyc(64);
    check("down_hold0", 32'(count_o), 32'd0);
    cyc(1);
    expect_out("down_wrap", 3'd7, 1'b1);
    cyc(63);
    check("down_hold7", 32'(count_o), 32'd7);
    cyc(1);
    expect_out("down_76", 3'd6, 1'b0);

    // Single step while paused
    run_i = 1'b0;
    dir_i = 1'b0;
    rate_i = 2'd0;
    cyc(1);
    do_load(3'd0);
    for (int p = 0; p < 3; p++) begin
      step_i = 1'b1;
      cyc(10);
      step_i = 1'b0;
      cyc(10);
      check($sformatf("step%0d", p), 32'(count_o), 32'(p + 1));
    end
    expect_out("step_final", 3'd3, 1'b0);

    // Step pulse during RUN is ignored
    run_i = 1'b1;
    step_i = 1'b1;
    cyc(4);
    step_i = 1'b0;
    cyc(4);
    check("run_step_ignored", 32'(count_o), 32'd3);
    cyc(1);
    check("run_after_step", 32'(count_o), 32'd4);

    // Load wins over a simultaneous tick
    cyc(7);
    check("pre5_hold", 32'(count_o), 32'd4);
    cyc(1);
    check("reach5", 32'(count_o), 32'd5);
    cyc(7);
    load_i = 1'b1;
    load_val_i = 3'd2;
    cyc(1);
    load_i = 1'b0;
    expect_out("load_prio", 3'd2, 1'b0);
    cyc(7);
    check("load_hold", 32'(count_o), 32'd2);
    cyc(1);
    check("load_next_tick", 32'(count_o), 32'd3);

    // Asynchronous reset mid-run at count 6
    for (int i = 4; i <= 6; i++) cyc(8);
    check("pre_reset6", 32'(count_o), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 3'd0, 1'b0);
    cyc(3);
    expect_out("reset_runhigh", 3'd0, 1'b0);
    rst_n = 1'b1;
    cyc(8);
    check("post_reset_hold", 32'(count_o), 32'd0);
    cyc(1);
    expect_out("post_reset_run", 3'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
